// File: rtl/memoria_responder.sv
// rtl/memoria_responder.sv - Req/Ack memory responder with programmable wait states
module memoria_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Req,
  input  logic                  Wren,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] Data,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Ack,
  output logic                  Busy,
  output logic [15:0]           AccessCount
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Wait counter preload; the zero-wait build skips WAIT entirely so its value is unused there.
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            cnt, cnt_next;
  logic                  capture;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  wren_q;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  acc_wren;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // State and wait counter registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: capture in IDLE, count down in WAIT, single RESP cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (Req) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_next = S_RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the capture edge, so use live inputs in IDLE.
  assign acc_addr = (state == S_IDLE) ? Address : addr_q;
  assign acc_data = (state == S_IDLE) ? Data    : data_q;
  assign acc_wren = (state == S_IDLE) ? Wren    : wren_q;
  assign commit   = Resetn && (state_next == S_RESP) && (state != S_RESP);

  // Capture registers hold the in-flight access so later bus changes are ignored.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      addr_q <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
    end else if (capture) begin
      addr_q <= Address;
      data_q <= Data;
      wren_q <= Wren;
    end
  end

  // Registered outputs decoded from the next state so Ack/Busy are glitch-free.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Ack         <= 1'b0;
      Busy        <= 1'b0;
      Q           <= '0;
      AccessCount <= 16'd0;
    end else begin
      Ack  <= (state_next == S_RESP);
      Busy <= (state_next != S_IDLE);
      if (commit) begin
        AccessCount <= AccessCount + 16'd1;
        if (!acc_wren) Q <= mem[acc_addr];
      end
    end
  end

  // Storage array is never cleared by reset.
  always_ff @(posedge Clock) begin
    if (commit && acc_wren) mem[acc_addr] <= acc_data;
  end

endmodule

// File: tb/tb_memoria_responder.sv
// tb/tb_memoria_responder.sv - self-checking bench for memoria_responder (W=2 and W=0 builds)
module tb_memoria_responder;

  logic        clk = 1'b0;
  logic        rst_n   [2];
  logic        req     [2];
  logic        wren    [2];
  logic [5:0]  address [2];
  logic [15:0] data_i  [2];
  logic [15:0] q       [2];
  logic        ack     [2];
  logic        busy    [2];
  logic [15:0] count   [2];

  int          wait_of [2] = '{2, 0};
  logic [15:0] ref_mem [2][64];
  logic [15:0] ref_cnt [2];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  memoria_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .WAIT_STATES(2)) u_dut0 (
    .Clock(clk), .Resetn(rst_n[0]), .Req(req[0]), .Wren(wren[0]), .Address(address[0]),
    .Data(data_i[0]), .Q(q[0]), .Ack(ack[0]), .Busy(busy[0]), .AccessCount(count[0])
  );

  memoria_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .WAIT_STATES(0)) u_dut1 (
    .Clock(clk), .Resetn(rst_n[1]), .Req(req[1]), .Wren(wren[1]), .Address(address[1]),
    .Data(data_i[1]), .Q(q[1]), .Ack(ack[1]), .Busy(busy[1]), .AccessCount(count[1])
  );

  // One access with a pulsed Req; bus is disturbed after capture. Returns observations only.
  task automatic access(input int d, input bit wr, input int addr, input logic [15:0] wd,
                        output int lat, output logic [15:0] qv, output bit post_ok);
    @(negedge clk);
    req[d] = 1'b1; wren[d] = wr; address[d] = 6'(addr); data_i[d] = wd;
    @(posedge clk);
    @(negedge clk);
    req[d] = 1'b0; address[d] = address[d] + 6'd1; data_i[d] = ~wd; wren[d] = ~wr;
    lat = 0; qv = '0; post_ok = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      if (!busy[d]) post_ok = 1'b0;
      if (ack[d]) begin lat = n; qv = q[d]; break; end
      @(negedge clk);
    end
    @(negedge clk);
    if (busy[d] || ack[d]) post_ok = 1'b0;
    if (lat != 0 && !wr && q[d] !== qv) post_ok = 1'b0;
    if (lat != 0) begin
      if (wr) ref_mem[d][addr] = wd;
      ref_cnt[d] = ref_cnt[d] + 16'd1;
    end
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (ack[d] !== 1'b0) begin n_bad++; $display("FAIL reset_ack[%0d]: got %b expected 0", d, ack[d]); end
      n_cmp++; if (busy[d] !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d]: got %b expected 0", d, busy[d]); end
      n_cmp++; if (q[d] !== 16'h0000) begin n_bad++; $display("FAIL reset_q[%0d]: got %h expected 0000", d, q[d]); end
      n_cmp++; if (count[d] !== 16'h0000) begin n_bad++; $display("FAIL reset_count[%0d]: got %h expected 0000", d, count[d]); end
    end
  endtask

  task automatic test_fill;
    int lat; logic [15:0] qv; bit ok;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 64; a++) begin
        access(d, 1'b1, a, 16'($urandom), lat, qv, ok);
        n_cmp++; if (lat != wait_of[d] + 1 || !ok) begin n_bad++; $display("FAIL fill_latency[%0d] addr %0d: got %0d ok=%0b expected %0d", d, a, lat, ok, wait_of[d] + 1); end
      end
    end
  endtask

  task automatic test_write_read;
    int lat; logic [15:0] qv; bit ok;
    access(0, 1'b1, 5, 16'h1234, lat, qv, ok);
    n_cmp++; if (lat != 3 || !ok) begin n_bad++; $display("FAIL wr_latency: got %0d ok=%0b expected 3", lat, ok); end
    access(0, 1'b0, 5, 16'h0000, lat, qv, ok);
    n_cmp++; if (lat != 3 || !ok) begin n_bad++; $display("FAIL rd_latency: got %0d ok=%0b expected 3", lat, ok); end
    n_cmp++; if (qv !== 16'h1234) begin n_bad++; $display("FAIL rd_after_wr: got %h expected 1234", qv); end
    n_cmp++; if (count[0] !== ref_cnt[0]) begin n_bad++; $display("FAIL wr_rd_count: got %h expected %h", count[0], ref_cnt[0]); end
  endtask

  task automatic test_zero_wait;
    int lat; logic [15:0] qv; bit ok;
    access(1, 1'b1, 63, 16'hA5A5, lat, qv, ok);
    n_cmp++; if (lat != 1 || !ok) begin n_bad++; $display("FAIL w0_wr_latency: got %0d ok=%0b expected 1", lat, ok); end
    access(1, 1'b0, 63, 16'h0000, lat, qv, ok);
    n_cmp++; if (lat != 1 || !ok) begin n_bad++; $display("FAIL w0_rd_latency: got %0d ok=%0b expected 1", lat, ok); end
    n_cmp++; if (qv !== 16'hA5A5) begin n_bad++; $display("FAIL w0_rd_data: got %h expected a5a5", qv); end
  endtask

  task automatic test_random;
    int lat; logic [15:0] qv; bit ok;
    for (int i = 0; i < 60; i++) begin
      int d; bit wr; int a; logic [15:0] wd; logic [15:0] exp;
      d = int'($urandom_range(0, 1)); wr = 1'($urandom); a = int'($urandom_range(0, 63)); wd = 16'($urandom);
      exp = ref_mem[d][a];
      access(d, wr, a, wd, lat, qv, ok);
      n_cmp++; if (lat != wait_of[d] + 1 || !ok) begin n_bad++; $display("FAIL rand_latency[%0d] #%0d: got %0d ok=%0b expected %0d", d, i, lat, ok, wait_of[d] + 1); end
      if (!wr) begin
        n_cmp++; if (qv !== exp) begin n_bad++; $display("FAIL rand_read[%0d] addr %0d: got %h expected %h", d, a, qv, exp); end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (count[d] !== ref_cnt[d]) begin n_bad++; $display("FAIL rand_count[%0d]: got %h expected %h", d, count[d], ref_cnt[d]); end
    end
  endtask

  // Req held high: reads of addresses 0..n-1, address advanced on each Ack.
  task automatic test_back_to_back(input int d, input int n);
    int ack_t [4]; logic [15:0] qs [4]; int k; int t;
    k = 0; t = 0;
    @(negedge clk);
    req[d] = 1'b1; wren[d] = 1'b0; address[d] = 6'd0;
    while (k < n && t < 60) begin
      @(negedge clk); t++;
      if (ack[d]) begin
        ack_t[k] = t; qs[k] = q[d]; k++;
        address[d] = 6'(k);
        if (k == n) req[d] = 1'b0;
      end
    end
    req[d] = 1'b0;
    n_cmp++; if (k != n) begin n_bad++; $display("FAIL b2b_acks[%0d]: got %0d expected %0d", d, k, n); end
    for (int i = 0; i < k; i++) begin
      n_cmp++; if (qs[i] !== ref_mem[d][i]) begin n_bad++; $display("FAIL b2b_data[%0d] #%0d: got %h expected %h", d, i, qs[i], ref_mem[d][i]); end
      if (i > 0) begin
        n_cmp++; if (ack_t[i] - ack_t[i-1] != wait_of[d] + 2) begin n_bad++; $display("FAIL b2b_period[%0d] #%0d: got %0d expected %0d", d, i, ack_t[i] - ack_t[i-1], wait_of[d] + 2); end
      end
    end
    ref_cnt[d] = ref_cnt[d] + 16'(k);
    repeat (3) @(negedge clk);
    n_cmp++; if (count[d] !== ref_cnt[d]) begin n_bad++; $display("FAIL b2b_count[%0d]: got %h expected %h", d, count[d], ref_cnt[d]); end
  endtask

  // Bus disturbed during WAIT (address+1, data inverted, Wren flipped) must not leak in.
  task automatic test_ignore;
    int lat; logic [15:0] qv; bit ok; logic [15:0] e5; logic [15:0] e6;
    e5 = ref_mem[0][5]; e6 = ref_mem[0][6];
    access(0, 1'b0, 5, 16'h0000, lat, qv, ok);
    n_cmp++; if (qv !== e5) begin n_bad++; $display("FAIL ignore_q: got %h expected %h", qv, e5); end
    access(0, 1'b0, 6, 16'h0000, lat, qv, ok);
    n_cmp++; if (qv !== e6) begin n_bad++; $display("FAIL ignore_mem6: got %h expected %h", qv, e6); end
  endtask

  // Reset during RESP: outputs clear at once; the committed write survives.
  task automatic test_reset_midrun;
    int lat; logic [15:0] qv; bit ok; logic [15:0] wd; bit seen;
    access(0, 1'b1, 7, 16'h5A5A, lat, qv, ok);
    access(0, 1'b0, 7, 16'h0000, lat, qv, ok);
    wd = 16'($urandom) | 16'h0001;
    @(negedge clk);
    req[0] = 1'b1; wren[0] = 1'b1; address[0] = 6'd20; data_i[0] = wd;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      if (ack[0]) seen = 1'b1; else @(negedge clk);
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL midrun_ack: got none expected pulse"); end
    rst_n[0] = 1'b0;
    #1;
    n_cmp++; if (ack[0] !== 1'b0) begin n_bad++; $display("FAIL midrun_ack_drop: got %b expected 0", ack[0]); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL midrun_busy: got %b expected 0", busy[0]); end
    n_cmp++; if (q[0] !== 16'h0000) begin n_bad++; $display("FAIL midrun_q: got %h expected 0000", q[0]); end
    n_cmp++; if (count[0] !== 16'h0000) begin n_bad++; $display("FAIL midrun_count: got %h expected 0000", count[0]); end
    ref_mem[0][20] = wd; ref_cnt[0] = 16'd0;
    @(negedge clk); rst_n[0] = 1'b1;
    access(0, 1'b0, 20, 16'h0000, lat, qv, ok);
    n_cmp++; if (qv !== wd) begin n_bad++; $display("FAIL midrun_write_kept: got %h expected %h", qv, wd); end
  endtask

  // Reset during WAIT: the write is aborted and Ack never pulses.
  task automatic test_abort;
    int lat; logic [15:0] qv; bit ok; bit seen;
    access(0, 1'b1, 9, 16'h0001, lat, qv, ok);
    @(negedge clk);
    req[0] = 1'b1; wren[0] = 1'b1; address[0] = 6'd9; data_i[0] = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    rst_n[0] = 1'b0;
    #1;
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy[0]); end
    ref_cnt[0] = 16'd0;
    @(negedge clk); rst_n[0] = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (ack[0] !== 1'b0) seen = 1'b1; end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL abort_no_ack: got pulse expected none"); end
    access(0, 1'b0, 9, 16'h0000, lat, qv, ok);
    n_cmp++; if (qv !== 16'h0001) begin n_bad++; $display("FAIL abort_mem: got %h expected 0001", qv); end
    n_cmp++; if (count[0] !== ref_cnt[0]) begin n_bad++; $display("FAIL abort_count: got %h expected %h", count[0], ref_cnt[0]); end
  endtask

  task automatic test_count_wrap;
    int lat; logic [15:0] qv; bit ok;
    @(negedge clk);
    force u_dut1.AccessCount = 16'hFFFF;
    #1 release u_dut1.AccessCount;
    ref_cnt[1] = 16'hFFFF;
    access(1, 1'b0, 3, 16'h0000, lat, qv, ok);
    n_cmp++; if (count[1] !== ref_cnt[1]) begin n_bad++; $display("FAIL count_wrap: got %h expected %h", count[1], ref_cnt[1]); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; wren[d] = 1'b0; address[d] = '0; data_i[d] = '0;
      ref_cnt[d] = 16'd0;
    end
    repeat (2) @(negedge clk);
    test_reset;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    test_fill;
    test_write_read;
    test_zero_wait;
    test_random;
    test_back_to_back(0, 4);
    test_back_to_back(1, 3);
    test_ignore;
    test_reset_midrun;
    test_abort;
    test_count_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
